// File: rtl/bm_match_mac_pipe.sv
// Multi-channel unsigned multiply / sum / accumulate pipeline.
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   in_valid, a_in, b_in : per-channel operand pairs, packed channel 0 at LSBs
//   acc_mode, acc_clear  : stage-3 controls, sampled alongside sum_valid
//   prod_valid/prod_out  : stage-1 registered products
//   sum_valid/sum_out    : stage-2 registered sum of products
//   acc_valid/acc_out    : stage-3 result pulse and held result
//   acc_count, overflow  : window fill level, sticky carry-out flag
module bm_match_mac_pipe #(
  parameter int unsigned CHANNELS  = 3,
  parameter int unsigned A_WIDTH   = 9,
  parameter int unsigned B_WIDTH   = 8,
  parameter int unsigned OUT_WIDTH = 36,
  parameter int unsigned ACC_LEN   = 4,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   in_valid,
  input  logic [CHANNELS*A_WIDTH-1:0]            a_in,
  input  logic [CHANNELS*B_WIDTH-1:0]            b_in,
  input  logic                                   acc_mode,
  input  logic                                   acc_clear,
  output logic                                   prod_valid,
  output logic [CHANNELS*(A_WIDTH+B_WIDTH)-1:0]  prod_out,
  output logic                                   sum_valid,
  output logic [OUT_WIDTH-1:0]                   sum_out,
  output logic                                   acc_valid,
  output logic [OUT_WIDTH-1:0]                   acc_out,
  output logic [CNT_WIDTH-1:0]                   acc_count,
  output logic                                   overflow
);

  localparam int unsigned PW = A_WIDTH + B_WIDTH;
  // Wide enough that the full adder-tree result never wraps internally.
  localparam int unsigned SW = OUT_WIDTH + $clog2(CHANNELS) + 1;
  localparam logic [CNT_WIDTH:0] LEN = (CNT_WIDTH+1)'(ACC_LEN);

  // Stage 1: per-channel products
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prod_valid <= 1'b0;
      prod_out   <= '0;
    end else begin
      prod_valid <= in_valid;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        prod_out[i*PW +: PW] <= PW'(a_in[i*A_WIDTH +: A_WIDTH]) *
                                PW'(b_in[i*B_WIDTH +: B_WIDTH]);
      end
    end
  end

  // Stage 2: sum of products
  logic [SW-1:0] sum_wide;
  logic          sum_carry;

  always_comb begin
    sum_wide = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      sum_wide = sum_wide + SW'(prod_out[i*PW +: PW]);
    end
  end

  assign sum_carry = prod_valid && (sum_wide[SW-1:OUT_WIDTH] != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum_valid <= 1'b0;
      sum_out   <= '0;
    end else begin
      sum_valid <= prod_valid;
      sum_out   <= sum_wide[OUT_WIDTH-1:0];
    end
  end

  // Stage 3: pass-through or windowed accumulate
  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH:0]   acc_total;
  logic [CNT_WIDTH:0]   cnt_inc;
  logic                 window_done;

  logic [OUT_WIDTH-1:0] acc_nxt;
  logic [OUT_WIDTH-1:0] out_nxt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 av_nxt;
  logic                 ovf_nxt;

  assign acc_total   = {1'b0, acc} + {1'b0, sum_out};
  assign cnt_inc     = {1'b0, acc_count} + (CNT_WIDTH+1)'(1);
  assign window_done = (cnt_inc == LEN);

  always_comb begin
    acc_nxt = acc;
    cnt_nxt = acc_count;
    out_nxt = acc_out;
    av_nxt  = 1'b0;
    ovf_nxt = overflow;

    if (acc_clear) begin
      acc_nxt = '0;
      cnt_nxt = '0;
      ovf_nxt = 1'b0;
    end

    if (sum_valid) begin
      if (acc_clear) begin
        // Coincident sum opens a fresh window rather than being dropped.
        if (!acc_mode || ACC_LEN == 1) begin
          out_nxt = sum_out;
          av_nxt  = 1'b1;
        end else begin
          acc_nxt = sum_out;
          cnt_nxt = CNT_WIDTH'(1);
        end
      end else if (!acc_mode) begin
        out_nxt = sum_out;
        av_nxt  = 1'b1;
        acc_nxt = '0;
        cnt_nxt = '0;
      end else begin
        ovf_nxt = ovf_nxt | acc_total[OUT_WIDTH];
        if (window_done) begin
          out_nxt = acc_total[OUT_WIDTH-1:0];
          av_nxt  = 1'b1;
          acc_nxt = '0;
          cnt_nxt = '0;
        end else begin
          acc_nxt = acc_total[OUT_WIDTH-1:0];
          cnt_nxt = cnt_inc[CNT_WIDTH-1:0];
        end
      end
    end

    // A carry arriving in the same cycle as a clear is still recorded.
    if (sum_carry) begin
      ovf_nxt = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      acc_count <= '0;
      acc_out   <= '0;
      acc_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      acc       <= acc_nxt;
      acc_count <= cnt_nxt;
      acc_out   <= out_nxt;
      acc_valid <= av_nxt;
      overflow  <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_bm_match_mac_pipe.sv
module tb_bm_match_mac_pipe;

  localparam int ACC_LEN = 4;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [26:0] a_in;
  logic [23:0] b_in;
  logic        acc_mode;
  logic        acc_clear;

  logic        pv36, sv36, av36, ovf36;
  logic [50:0] po36;
  logic [35:0] so36, ao36;
  logic [7:0]  cnt36;

  logic        pv18, sv18, av18, ovf18;
  logic [50:0] po18;
  logic [17:0] so18, ao18;
  logic [7:0]  cnt18;

  int n_tests = 0;
  int n_fail  = 0;

  bm_match_mac_pipe dut (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .a_in(a_in), .b_in(b_in), .acc_mode(acc_mode), .acc_clear(acc_clear),
    .prod_valid(pv36), .prod_out(po36), .sum_valid(sv36), .sum_out(so36),
    .acc_valid(av36), .acc_out(ao36), .acc_count(cnt36), .overflow(ovf36)
  );

  bm_match_mac_pipe #(.OUT_WIDTH(18)) dut18 (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .a_in(a_in), .b_in(b_in), .acc_mode(acc_mode), .acc_clear(acc_clear),
    .prod_valid(pv18), .prod_out(po18), .sum_valid(sv18), .sum_out(so18),
    .acc_valid(av18), .acc_out(ao18), .acc_count(cnt18), .overflow(ovf18)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  typedef struct {
    bit              v;
    longint unsigned p0, p1, p2;
    longint unsigned raw;
  } samp_t;

  samp_t           s1, s2;          // sample visible at product / sum outputs
  longint unsigned win[$];          // raw sums belonging to the open window
  bit              e_av;
  longint unsigned e_out [2];
  bit              e_ovf [2];

  function automatic longint unsigned lim(input int k);
    return (k == 0) ? 64'h10_0000_0000 : 64'h4_0000;
  endfunction

  function automatic longint unsigned win_total(input int k);
    longint unsigned t = 0;
    foreach (win[i]) t += win[i] % lim(k);
    return t;
  endfunction

  task automatic emit_raw(input longint unsigned raw);
    e_av = 1'b1;
    for (int k = 0; k < 2; k++) e_out[k] = raw % lim(k);
  endtask

  task automatic model_step();
    samp_t nw;
    if (reset) begin
      s1 = '{default: 0};
      s2 = '{default: 0};
      win.delete();
      e_av  = 1'b0;
      e_out = '{default: 0};
      e_ovf = '{default: 0};
    end else begin
      nw.v   = in_valid;
      nw.p0  = 64'(a_in[8:0])   * 64'(b_in[7:0]);
      nw.p1  = 64'(a_in[17:9])  * 64'(b_in[15:8]);
      nw.p2  = 64'(a_in[26:18]) * 64'(b_in[23:16]);
      nw.raw = nw.p0 + nw.p1 + nw.p2;
      e_av = 1'b0;
      if (s2.v) begin
        if (acc_clear) begin
          e_ovf = '{default: 0};
          win.delete();
          if (!acc_mode || ACC_LEN == 1) emit_raw(s2.raw);
          else win.push_back(s2.raw);
        end else if (!acc_mode) begin
          win.delete();
          emit_raw(s2.raw);
        end else begin
          win.push_back(s2.raw);
          for (int k = 0; k < 2; k++)
            if (win_total(k) >= lim(k)) e_ovf[k] = 1'b1;
          if (win.size() == ACC_LEN) begin
            e_av = 1'b1;
            for (int k = 0; k < 2; k++) e_out[k] = win_total(k) % lim(k);
            win.delete();
          end
        end
      end else if (acc_clear) begin
        win.delete();
        e_ovf = '{default: 0};
      end
      s2 = s1;
      s1 = nw;
      for (int k = 0; k < 2; k++)
        if (s2.v && s2.raw >= lim(k)) e_ovf[k] = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clock or posedge reset);
    model_step();
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input string tag, input int k,
                          input logic pv, input logic [50:0] po,
                          input logic sv, input logic [63:0] so,
                          input logic av, input logic [63:0] ao,
                          input logic [7:0] cnt, input logic ovf);
    logic [50:0] ep;
    ep = {17'(s1.p2), 17'(s1.p1), 17'(s1.p0)};
    check({tag, "_prod_valid"}, 64'(pv), 64'(s1.v));
    check({tag, "_prod_out"}, 64'(po), 64'(ep));
    check({tag, "_sum_valid"}, 64'(sv), 64'(s2.v));
    check({tag, "_sum_out"}, so, s2.raw % lim(k));
    check({tag, "_acc_valid"}, 64'(av), 64'(e_av));
    check({tag, "_acc_out"}, ao, e_out[k]);
    check({tag, "_acc_count"}, 64'(cnt), 64'(win.size()));
    check({tag, "_overflow"}, 64'(ovf), 64'(e_ovf[k]));
  endtask

  initial forever begin
    @(negedge clock);
    cmp_inst("m36", 0, pv36, po36, sv36, 64'(so36), av36, 64'(ao36), cnt36, ovf36);
    cmp_inst("m18", 1, pv18, po18, sv18, 64'(so18), av18, 64'(ao18), cnt18, ovf18);
  end

  // ---------------- directed stimulus ----------------
  task automatic set_in(input logic v, input logic [8:0] a2, a1, a0,
                        input logic [7:0] b2, b1, b0);
    in_valid = v;
    a_in     = {a2, a1, a0};
    b_in     = {b2, b1, b0};
  endtask

  task automatic idle();
    set_in(1'b0, 9'd0, 9'd0, 9'd0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic nxt();
    @(negedge clock);
    #1;
  endtask

  task automatic std_vec();
    set_in(1'b1, 9'd3, 9'd2, 9'd1, 8'd6, 8'd5, 8'd4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; acc_mode = 1'b0; acc_clear = 1'b0;
    idle();
    #1 reset = 1'b1;
    repeat (2) nxt();
    check("rst_prod_valid", 64'(pv36), 0);
    check("rst_sum_valid",  64'(sv36), 0);
    check("rst_acc_valid",  64'(av36), 0);
    check("rst_acc_out",    64'(ao36), 0);
    check("rst_acc_count",  64'(cnt36), 0);
    check("rst_overflow",   64'(ovf36), 0);
    reset = 1'b0;
    nxt();

    // pass mode, single sample
    std_vec(); nxt();
    check("t1_prod_valid", 64'(pv36), 1);
    check("t1_prod_out", 64'(po36), {13'd0, 17'd18, 17'd10, 17'd4});
    idle(); nxt();
    check("t1_sum_valid", 64'(sv36), 1);
    check("t1_sum_out", 64'(so36), 32);
    nxt();
    check("t1_acc_valid", 64'(av36), 1);
    check("t1_acc_out", 64'(ao36), 32);
    nxt();
    check("t1_no_pulse", 64'(av36), 0);
    check("t1_hold", 64'(ao36), 32);
    repeat (2) nxt();

    // accumulate, four back-to-back samples
    acc_mode = 1'b1;
    std_vec(); nxt(); nxt();
    nxt(); check("t2_cnt1", 64'(cnt36), 1);
    nxt(); check("t2_cnt2", 64'(cnt36), 2);
    idle();
    nxt(); check("t2_cnt3", 64'(cnt36), 3); check("t2_no_early", 64'(av36), 0);
    nxt(); check("t2_acc_valid", 64'(av36), 1); check("t2_acc_out", 64'(ao36), 128);
           check("t2_cnt0", 64'(cnt36), 0);
    nxt(); check("t2_single", 64'(av36), 0);

    // bubbles inside a window
    std_vec(); nxt(); nxt();
    idle();
    nxt(); check("t3_cnt1", 64'(cnt36), 1);
    nxt(); check("t3_cnt2a", 64'(cnt36), 2);
    nxt(); check("t3_cnt2b", 64'(cnt36), 2);
    std_vec();
    nxt(); check("t3_cnt2c", 64'(cnt36), 2);
    nxt(); check("t3_cnt2d", 64'(cnt36), 2);
    idle();
    nxt(); check("t3_cnt3", 64'(cnt36), 3);
    nxt(); check("t3_acc_valid", 64'(av36), 1); check("t3_acc_out", 64'(ao36), 128);
    nxt(); repeat (2) nxt();

    // clear coincident with third sum of a window
    std_vec(); nxt(); nxt();
    nxt(); check("t5_cnt1", 64'(cnt36), 1);
    nxt(); check("t5_cnt2", 64'(cnt36), 2);
    acc_clear = 1'b1;
    nxt(); check("t5_restart", 64'(cnt36), 1); check("t5_no_pulse", 64'(av36), 0);
    acc_clear = 1'b0;
    nxt(); check("t5_cnt2b", 64'(cnt36), 2);
    idle();
    nxt(); check("t5_cnt3", 64'(cnt36), 3);
    nxt(); check("t5_acc_valid", 64'(av36), 1); check("t5_acc_out", 64'(ao36), 128);
    repeat (2) nxt();

    // maximum operands: stage-2 wrap on the narrow instance
    acc_mode = 1'b0;
    set_in(1'b1, 9'd511, 9'd511, 9'd511, 8'd255, 8'd255, 8'd255); nxt();
    idle(); nxt();
    check("t4_sum36", 64'(so36), 390915); check("t4_ovf36", 64'(ovf36), 0);
    check("t4_sum18", 64'(so18), 128771); check("t4_ovf18", 64'(ovf18), 1);
    nxt(); check("t4_acc18", 64'(ao18), 128771);
    repeat (3) nxt();
    check("t4_sticky", 64'(ovf18), 1);
    acc_clear = 1'b1; nxt(); acc_clear = 1'b0;
    check("t4_cleared", 64'(ovf18), 0);
    nxt();

    // accumulate carry on the narrow instance
    acc_mode = 1'b1;
    set_in(1'b1, 9'd0, 9'd511, 9'd511, 8'd0, 8'd255, 8'd255); nxt(); nxt();
    nxt(); check("t7_ovf18_first", 64'(ovf18), 0);
    nxt(); check("t7_ovf18_second", 64'(ovf18), 1);
    idle(); nxt();
    nxt(); check("t7_acc36", 64'(ao36), 1042440); check("t7_acc18", 64'(ao18), 256008);
           check("t7_ovf36", 64'(ovf36), 0);
    acc_clear = 1'b1; nxt(); acc_clear = 1'b0;
    nxt();

    // reset mid-window with samples in flight
    std_vec(); nxt(); nxt();
    nxt(); check("t6_cnt1", 64'(cnt36), 1);
    idle();
    reset = 1'b1;
    #1;
    check("t6_prod_valid", 64'(pv36), 0);
    check("t6_prod_out", 64'(po36), 0);
    check("t6_sum_valid", 64'(sv36), 0);
    check("t6_sum_out", 64'(so36), 0);
    check("t6_acc_valid", 64'(av36), 0);
    check("t6_acc_out", 64'(ao36), 0);
    check("t6_acc_count", 64'(cnt36), 0);
    check("t6_overflow", 64'(ovf36), 0);
    nxt();
    reset = 1'b0;
    acc_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nxt();
      check("t6_quiet_pv", 64'(pv36), 0);
      check("t6_quiet_sv", 64'(sv36), 0);
      check("t6_quiet_av", 64'(av36), 0);
    end
    std_vec(); nxt();
    idle(); nxt(); nxt();
    check("t6_after_av", 64'(av36), 1);
    check("t6_after_out", 64'(ao36), 32);
    repeat (2) nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
